// File: rtl/uart_rx_parity_check_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_parity_check_if
//  Purpose  : Bundles the baud-enable, serial line, frame-control inputs and
//             received-word outputs of the UART receiver.
//  Modports : master - drives baud_tick, rx_serial, parity_en, err_inj_en;
//                      observes the received word and status flags.
//             slave  - the receiver side (mirror of master).
//  Signals  : baud_tick     1          enable pulse at OVERSAMPLE x baud
//             rx_serial     1          asynchronous serial line, idles high
//             parity_en     1          frame carries a parity bit
//             err_inj_en    1          request inverted parity check
//             data_valid    1          one-clk frame-complete pulse
//             parallel_data DATA_WIDTH last received word
//             parity_err    1          parity mismatch on last frame
//             frame_err     1          stop bit sampled low on last frame
//             busy          1          receiver not idle
//             err_inj_done  1          injected frame completed
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_parity_check_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  baud_tick;
    logic                  rx_serial;
    logic                  parity_en;
    logic                  err_inj_en;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;
    logic                  err_inj_done;

    modport master (
        output baud_tick, rx_serial, parity_en, err_inj_en,
        input  data_valid, parallel_data, parity_err, frame_err, busy,
               err_inj_done
    );

    modport slave (
        input  baud_tick, rx_serial, parity_en, err_inj_en,
        output data_valid, parallel_data, parity_err, frame_err, busy,
               err_inj_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_parity_check.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_parity_check
//  Purpose  : 16x-oversampling UART receiver with optional odd-parity check,
//             stop-bit (framing) check and optional parity-error injection.
//  Ports    : clk    - system clock
//             reset  - asynchronous, active-low reset
//             bus    - uart_rx_parity_check_if.slave (line, baud enable,
//                      frame controls, received word and status flags)
//  Params   : DATA_WIDTH - data bits per frame
//             OVERSAMPLE - baud_tick pulses per bit (even, >= 4)
//  Macro    : UART_RX_ERR_INJ_EN - when defined, a latched err_inj_en
//             inverts the parity check of that frame and err_inj_done
//             pulses with its data_valid; otherwise err_inj_en is ignored
//             and err_inj_done is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_parity_check #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_rx_parity_check_if.slave  bus
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Line synchronizer (both stages reset to the idle level)
    logic sync1_q, sync2_q;

    // Receive datapath / control
    logic [2:0]            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [BIT_W-1:0]      bit_q,       bit_d;
    logic                  arm_q,       arm_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  par_en_q,    par_en_d;
    logic                  inj_q,       inj_d;
    logic                  par_bad_q,   par_bad_d;
    logic                  stop_low_q,  stop_low_d;
    logic                  done_q,      done_d;

    // Registered outputs
    logic                  data_valid_q,   data_valid_d;
    logic [DATA_WIDTH-1:0] par_data_q,     par_data_d;
    logic                  parity_err_q,   parity_err_d;
    logic                  frame_err_q,    frame_err_d;
    logic                  busy_q,         busy_d;
    logic                  inj_done_q,     inj_done_d;

    logic w_line;
    logic w_tick;
    logic w_inj;
    logic w_exp_par;

    assign w_line = sync2_q;
    assign w_tick = bus.baud_tick;

`ifdef UART_RX_ERR_INJ_EN
    assign w_inj = inj_q;
`else
    logic w_unused_inj;
    assign w_inj        = 1'b0;
    assign w_unused_inj = inj_q;
`endif

    // Odd parity: the parity bit makes the total count of ones odd.
    // Injection flips the expectation so a correct frame is flagged.
    assign w_exp_par = w_inj ? (^shift_q) : (~^shift_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        arm_d      = arm_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        inj_d      = inj_q;
        par_bad_d  = par_bad_q;
        stop_low_d = stop_low_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_tick) begin
                    if (w_line) begin
                        arm_d = 1'b1;
                    end else if (arm_q) begin
                        // Falling edge seen after the line was high
                        state_d = START;
                        cnt_d   = '0;
                        arm_d   = 1'b0;
                    end
                end
            end
            START: begin
                if (w_tick) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (!w_line) begin
                            state_d   = DATA;
                            bit_d     = '0;
                            par_en_d  = bus.parity_en;
                            inj_d     = bus.err_inj_en;
                            par_bad_d = 1'b0;
                        end else begin
                            // Glitch: line already high again, so re-arm
                            state_d = IDLE;
                            arm_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d                 = '0;
                        shift_d               = shift_q >> 1;
                        shift_d[DATA_WIDTH-1] = w_line;
                        if (bit_q == BIT_LAST) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        par_bad_d = (w_line != w_exp_par);
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        stop_low_d = !w_line;
                        done_d     = 1'b1;
                        // A low stop bit must be followed by a high line
                        // before another start is accepted.
                        arm_d      = w_line;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output stage: one clk after the stop sample, so busy falls on the
    // same edge that data_valid rises.
    always_comb begin
        data_valid_d = done_q;
        par_data_d   = par_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        inj_done_d   = done_q & w_inj;
        busy_d       = (state_q != IDLE);
        if (done_q) begin
            par_data_d   = shift_q;
            parity_err_d = par_bad_q & par_en_q;
            frame_err_d  = stop_low_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            arm_q        <= 1'b0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            inj_q        <= 1'b0;
            par_bad_q    <= 1'b0;
            stop_low_q   <= 1'b0;
            done_q       <= 1'b0;
            data_valid_q <= 1'b0;
            par_data_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            inj_done_q   <= 1'b0;
        end else begin
            sync1_q      <= bus.rx_serial;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            arm_q        <= arm_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            inj_q        <= inj_d;
            par_bad_q    <= par_bad_d;
            stop_low_q   <= stop_low_d;
            done_q       <= done_d;
            data_valid_q <= data_valid_d;
            par_data_q   <= par_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            inj_done_q   <= inj_done_d;
        end
    end

    assign bus.data_valid    = data_valid_q;
    assign bus.parallel_data = par_data_q;
    assign bus.parity_err    = parity_err_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.busy          = busy_q;
    assign bus.err_inj_done  = inj_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_parity_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_parity_check
//  Purpose  : Directed frames into uart_rx_parity_check; expected words and
//             flags are queued at stimulus time and checked by a monitor
//             whenever data_valid is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_parity_check;

    localparam int DW = 8;
    localparam int OS = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_rx_parity_check_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_parity_check #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          fe;
        logic          inj;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef UART_RX_ERR_INJ_EN
    localparam logic INJ_ON = 1'b1;
`else
    localparam logic INJ_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // baud_tick: one clk in every four
    initial begin
        int div = 0;
        bus.baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.baud_tick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (!bus.baud_tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        @(negedge clk);
        bus.rx_serial = b;
        wait_ticks(n);
    endtask

    // Sends one frame; controls are flipped after the start bit to show
    // they are only latched at start validation.
    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit,
                              input logic stopb, input logic inj,
                              input logic exp_pe, input logic exp_fe, input logic exp_inj);
        exp_t e;
        e.data = d; e.pe = exp_pe; e.fe = exp_fe; e.inj = exp_inj;
        @(negedge clk);
        bus.parity_en  = pen;
        bus.err_inj_en = inj;
        q.push_back(e);
        drive_bit(1'b0, OS);
        bus.parity_en  = ~pen;
        bus.err_inj_en = ~inj;
        for (int i = 0; i < DW; i++) drive_bit(d[i], OS);
        if (pen) drive_bit(pbit, OS);
        drive_bit(stopb, OS);
        @(negedge clk);
        bus.rx_serial  = 1'b1;
        bus.parity_en  = 1'b0;
        bus.err_inj_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " data_valid"},    32'(bus.data_valid),    32'h0);
        chk({tag, " parallel_data"}, 32'(bus.parallel_data), 32'h0);
        chk({tag, " parity_err"},    32'(bus.parity_err),    32'h0);
        chk({tag, " frame_err"},     32'(bus.frame_err),     32'h0);
        chk({tag, " busy"},          32'(bus.busy),          32'h0);
        chk({tag, " err_inj_done"},  32'(bus.err_inj_done),  32'h0);
    endtask

    // Monitor: pops one expectation per data_valid cycle
    always @(negedge clk) begin
        if (bus.err_inj_done && !bus.data_valid)
            chk("err_inj_done without data_valid", 32'h1, 32'h0);
        if (bus.data_valid) begin
            if (q.size() == 0) begin
                chk("unexpected data_valid", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("parallel_data", 32'(bus.parallel_data), 32'(e.data));
                chk("parity_err",    32'(bus.parity_err),    32'(e.pe));
                chk("frame_err",     32'(bus.frame_err),     32'(e.fe));
                chk("err_inj_done",  32'(bus.err_inj_done),  32'(e.inj));
                chk("busy at data_valid", 32'(bus.busy),     32'h0);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.rx_serial  = 1'b1;
        bus.parity_en  = 1'b0;
        bus.err_inj_en = 1'b0;
        reset          = 1'b0;
        repeat (4) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        wait_ticks(4);

        // data, pen, pbit, stop, inj,  exp parity_err, frame_err, inj_done
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // 3 ones + 0 -> odd
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // even -> error
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // low stop
        wait_ticks(20);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // 4 ones + 1 -> odd
        send_frame(8'hFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // 7 ones + 1 -> even
        wait_ticks(4);

        // Low glitch of 4 ticks
        drive_bit(1'b0, 3);
        @(negedge clk);
        chk("glitch busy high", 32'(bus.busy), 32'h1);
        wait_ticks(1);
        drive_bit(1'b1, 10);
        @(negedge clk);
        chk("glitch busy low", 32'(bus.busy), 32'h0);
        wait_ticks(4);

        // Reset in the middle of data bit 3 (previous word 0xFE still held)
        chk("held parallel_data", 32'(bus.parallel_data), 32'hFE);
        drive_bit(1'b0, OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b1, OS / 2);
        @(negedge clk);
        chk("busy mid-frame", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        #1;
        chk_all_zero("mid-frame reset");
        @(negedge clk);
        bus.rx_serial = 1'b1;
        reset         = 1'b1;
        wait_ticks(6);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Injection: correctly odd frame, then injection on a no-parity frame
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, INJ_ON, 1'b0, INJ_ON);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,   1'b0, INJ_ON);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,   1'b0, 1'b0);

        repeat (20) @(negedge clk);
        chk("frames outstanding", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
